// File: rtl/regfile_2r1w_sb.sv
// regfile_2r1w_sb
//   Architectural register bank for the LEGv8 datapath: 32 x N-bit registers,
//   two combinational read ports and one synchronous write port. It also
//   provides same-cycle write-to-read bypass, X31 (XZR) hardwired to zero,
//   and a pending-write scoreboard that decode uses to stall on RAW hazards.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   RA1/RA2             read addresses
//   RU1/RU2             operand actually used this cycle (stall qualification)
//   RD1/RD2             read data (X31 reads 0, bypass from WD when WA matches)
//   WE/WA/WD            writeback-stage write port (WA=31 dropped)
//   IssueEn/IssueRd     destination register of an instruction issuing now
//   Busy1/Busy2         read address has an outstanding write not yet available
//   Stall               (RU1 & Busy1) | (RU2 & Busy2)
//   PendCnt             registered count of pending registers (0..31)
module regfile_2r1w_sb #(
    parameter int unsigned N = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [4:0]   RA1,
    input  logic [4:0]   RA2,
    input  logic         RU1,
    input  logic         RU2,
    output logic [N-1:0] RD1,
    output logic [N-1:0] RD2,
    input  logic         WE,
    input  logic [4:0]   WA,
    input  logic [N-1:0] WD,
    input  logic         IssueEn,
    input  logic [4:0]   IssueRd,
    output logic         Busy1,
    output logic         Busy2,
    output logic         Stall,
    output logic [5:0]   PendCnt
);

    logic [N-1:0] bank [32];
    logic [31:0]  pending;
    logic [31:0]  pending_next;
    logic [5:0]   cnt_next;

    // Write and issue fields are only looked at under their enables, so
    // undefined addresses on an idle port cannot disturb state.
    always_comb begin
        pending_next = pending;
        if (WE)
            pending_next[WA] = 1'b0;
        // Set is applied after clear: a newer producer wins over the
        // writeback of an older one to the same register.
        if (IssueEn && (IssueRd != 5'd31))
            pending_next[IssueRd] = 1'b1;
        pending_next[31] = 1'b0;
    end

    // PendCnt is the popcount of the value pending takes at the same edge.
    always_comb begin
        cnt_next = '0;
        for (int unsigned i = 0; i < 32; i++)
            cnt_next = cnt_next + 6'(pending_next[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++)
                bank[i] <= '0;
            pending <= '0;
            PendCnt <= '0;
        end else begin
            if (WE && (WA != 5'd31))
                bank[WA] <= WD;
            pending <= pending_next;
            PendCnt <= cnt_next;
        end
    end

    logic hit1, hit2;

    assign hit1 = WE && (WA == RA1);
    assign hit2 = WE && (WA == RA2);

    always_comb begin
        if (RA1 == 5'd31)
            RD1 = '0;
        else if (hit1)
            RD1 = WD;
        else
            RD1 = bank[RA1];
    end

    always_comb begin
        if (RA2 == 5'd31)
            RD2 = '0;
        else if (hit2)
            RD2 = WD;
        else
            RD2 = bank[RA2];
    end

    // A register whose value is being written this cycle is served by the
    // bypass, so it is not busy even though pending is still set.
    assign Busy1 = pending[RA1] && !hit1 && (RA1 != 5'd31);
    assign Busy2 = pending[RA2] && !hit2 && (RA2 != 5'd31);
    assign Stall = (RU1 && Busy1) || (RU2 && Busy2);

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
`timescale 1ns/100ps
module tb_regfile_2r1w_sb;

    logic        clk;
    logic        rst;
    logic [4:0]  RA1, RA2;
    logic        RU1, RU2;
    logic [63:0] RD1, RD2;
    logic        WE;
    logic [4:0]  WA;
    logic [63:0] WD;
    logic        IssueEn;
    logic [4:0]  IssueRd;
    logic        Busy1, Busy2, Stall;
    logic [5:0]  PendCnt;

    int unsigned checks = 0;
    int unsigned errors = 0;

    localparam logic [63:0] V5  = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] V30 = 64'hA5A5_5A5A_0F0F_F0F0;

    regfile_2r1w_sb #(.N(64)) dut (
        .clk     (clk),
        .rst     (rst),
        .RA1     (RA1),
        .RA2     (RA2),
        .RU1     (RU1),
        .RU2     (RU2),
        .RD1     (RD1),
        .RD2     (RD2),
        .WE      (WE),
        .WA      (WA),
        .WD      (WD),
        .IssueEn (IssueEn),
        .IssueRd (IssueRd),
        .Busy1   (Busy1),
        .Busy2   (Busy2),
        .Stall   (Stall),
        .PendCnt (PendCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        RA1 = '0; RA2 = '0; RU1 = 1'b0; RU2 = 1'b0;
        WE = 1'b0; WA = '0; WD = '0;
        IssueEn = 1'b0; IssueRd = '0;

        // Reset: every address reads zero on both ports, nothing busy.
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            RA1 = 5'(i); RA2 = 5'(31 - i); RU1 = 1'b1; RU2 = 1'b1;
            #0.2;
            check("rst_rd1", RD1, 64'd0);
            check("rst_rd2", RD2, 64'd0);
            check("rst_stall", {62'd0, Busy1, Busy2}, 64'd0);
            check("rst_stall2", {63'd0, Stall}, 64'd0);
        end
        check("rst_pendcnt", {58'd0, PendCnt}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        RU1 = 1'b0; RU2 = 1'b0;
        @(negedge clk);
        check("post_rst_pendcnt", {58'd0, PendCnt}, 64'd0);

        // Write reg 5 with same-cycle bypass, then read from the bank.
        @(negedge clk);
        WE = 1'b1; WA = 5'd5; WD = V5; RA1 = 5'd5; RA2 = 5'd0;
        #1;
        check("bypass_rd1", RD1, V5);
        check("bypass_rd2_other", RD2, 64'd0);
        @(negedge clk);
        WE = 1'b0;
        #1;
        check("bank_rd1", RD1, V5);

        // Write reg 30; both ports on the same register.
        @(negedge clk);
        WE = 1'b1; WA = 5'd30; WD = V30; RA1 = 5'd30; RA2 = 5'd30;
        #1;
        check("bypass_both_rd1", RD1, V30);
        check("bypass_both_rd2", RD2, V30);
        @(negedge clk);
        WE = 1'b0;
        #1;
        check("bank_both_rd1", RD1, V30);
        check("bank_both_rd2", RD2, V30);

        // Write to X31 is dropped and X31 always reads zero, even mid-write.
        @(negedge clk);
        WE = 1'b1; WA = 5'd31; WD = '1; RA1 = 5'd31; RA2 = 5'd31;
        #1;
        check("xzr_wr_rd1", RD1, 64'd0);
        check("xzr_wr_rd2", RD2, 64'd0);
        @(negedge clk);
        WE = 1'b0;
        #1;
        check("xzr_rd1", RD1, 64'd0);
        check("xzr_rd2", RD2, 64'd0);
        for (int i = 0; i < 31; i++) begin
            RA1 = 5'(i); RA2 = 5'(i);
            #0.2;
            check("bank_scan_rd1", RD1, (i == 5) ? V5 : (i == 30) ? V30 : 64'd0);
            check("bank_scan_rd2", RD2, (i == 5) ? V5 : (i == 30) ? V30 : 64'd0);
        end

        // Idle ports with undefined addresses must not touch state.
        @(negedge clk);
        WA = 'x; WD = 'x; IssueRd = 'x;
        @(negedge clk);
        WA = '0; WD = '0; IssueRd = '0;
        RA1 = 5'd5;
        #1;
        check("x_idle_rd1", RD1, V5);
        check("x_idle_pendcnt", {58'd0, PendCnt}, 64'd0);

        // Scoreboard: issue reg 9, stall while pending, clear on writeback.
        @(negedge clk);
        IssueEn = 1'b1; IssueRd = 5'd9;
        @(negedge clk);
        IssueEn = 1'b0; RA1 = 5'd9; RU1 = 1'b1;
        #1;
        check("sb9_busy1", {63'd0, Busy1}, 64'd1);
        check("sb9_stall", {63'd0, Stall}, 64'd1);
        check("sb9_pendcnt", {58'd0, PendCnt}, 64'd1);
        @(negedge clk);
        #1;
        check("sb9_busy1_hold", {63'd0, Busy1}, 64'd1);
        @(negedge clk);
        WE = 1'b1; WA = 5'd9; WD = 64'h0000_0000_0000_0099;
        #1;
        check("sb9_wb_busy1", {63'd0, Busy1}, 64'd0);
        check("sb9_wb_stall", {63'd0, Stall}, 64'd0);
        check("sb9_wb_rd1", RD1, 64'h99);
        @(negedge clk);
        WE = 1'b0;
        #1;
        check("sb9_clr_pendcnt", {58'd0, PendCnt}, 64'd0);
        check("sb9_clr_busy1", {63'd0, Busy1}, 64'd0);
        RU1 = 1'b0;

        // Set beats clear on the same register in the same cycle.
        @(negedge clk);
        IssueEn = 1'b1; IssueRd = 5'd12;
        @(negedge clk);
        IssueEn = 1'b0;
        #1;
        check("sb12_pendcnt", {58'd0, PendCnt}, 64'd1);
        @(negedge clk);
        IssueEn = 1'b1; IssueRd = 5'd12;
        WE = 1'b1; WA = 5'd12; WD = 64'h1212;
        @(negedge clk);
        IssueEn = 1'b0; WE = 1'b0;
        RA2 = 5'd12; RU2 = 1'b0;
        #1;
        check("sb12_pendcnt_same", {58'd0, PendCnt}, 64'd1);
        check("sb12_busy2", {63'd0, Busy2}, 64'd1);
        check("sb12_stall_unused", {63'd0, Stall}, 64'd0);
        RU2 = 1'b1;
        #1;
        check("sb12_stall_used", {63'd0, Stall}, 64'd1);
        // Re-issue to an already pending register leaves count at 1.
        IssueEn = 1'b1; IssueRd = 5'd12;
        @(negedge clk);
        IssueEn = 1'b0; RU2 = 1'b0;
        #1;
        check("sb12_reissue_cnt", {58'd0, PendCnt}, 64'd1);
        // Issue to X31 is ignored.
        IssueEn = 1'b1; IssueRd = 5'd31;
        @(negedge clk);
        IssueEn = 1'b0; RA1 = 5'd31;
        #1;
        check("sb31_cnt", {58'd0, PendCnt}, 64'd1);
        check("sb31_busy1", {63'd0, Busy1}, 64'd0);

        // Fill 1..20 (12 already pending) then reset asynchronously.
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            IssueEn = 1'b1; IssueRd = 5'(i);
        end
        @(negedge clk);
        IssueEn = 1'b0; RA1 = 5'd3; RU1 = 1'b1;
        #1;
        check("fill_pendcnt", {58'd0, PendCnt}, 64'd20);
        check("fill_stall", {63'd0, Stall}, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #0.2;
        check("arst_pendcnt", {58'd0, PendCnt}, 64'd0);
        check("arst_stall", {63'd0, Stall}, 64'd0);
        RU2 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            RA1 = 5'(i); RA2 = 5'(i);
            #0.2;
            check("arst_rd1", RD1, 64'd0);
            check("arst_rd2", RD2, 64'd0);
            check("arst_busy", {62'd0, Busy1, Busy2}, 64'd0);
        end
        check("arst_stall_end", {63'd0, Stall}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
